bch_enc_arbiter: RTL and testbench

BCH_ENC_ARBITER -- requirements
Module: bch_enc_arbiter

---
 rtl/bch_enc_arbiter.sv | 109 ++++++++++
 tb/tb_bch_enc_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bch_enc_arbiter.sv
// Two-requester round-robin front end for a shared BCH(15,7) encoder core.
// One transaction in flight; a hung core is abandoned after TIMEOUT wait cycles.
module bch_enc_arbiter #(
  parameter int MSG_W   = 7,
  parameter int CW_W    = 15,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [MSG_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [MSG_W-1:0] req1_data,
  output logic             req1_ready,
  output logic             core_start,
  output logic [MSG_W-1:0] core_msg,
  input  logic             core_done,
  input  logic [CW_W-1:0]  core_cw,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [CW_W-1:0]  rsp_cw,
  output logic             rsp_id,
  output logic             timeout_err,
  output logic [7:0]       err_cnt
);

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           r_state, w_next;
  logic             r_last;
  logic [7:0]       r_timer;
  logic [MSG_W-1:0] r_msg;
  logic [CW_W-1:0]  r_cw;
  logic             r_id;
  logic [7:0]       r_err;
  logic             w_gnt, w_hs0, w_hs1, w_hs, w_timeout;

  // Tie goes to whoever was not served last; otherwise the lone requester.
  assign w_gnt     = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_hs0     = (r_state == S_IDLE) && req0_valid && !w_gnt;
  assign w_hs1     = (r_state == S_IDLE) && req1_valid && w_gnt;
  assign w_hs      = w_hs0 || w_hs1;
  assign w_timeout = (r_state == S_WAIT) && !core_done && (r_timer == TMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_hs) w_next = S_START;
      S_START: w_next = S_WAIT;
      S_WAIT: begin
        if (core_done)      w_next = S_RESP;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req0_ready  = w_hs0;
    req1_ready  = w_hs1;
    core_start  = (r_state == S_START);
    rsp_valid   = (r_state == S_RESP);
    timeout_err = w_timeout;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last  <= 1'b1;
      r_timer <= '0;
      r_msg   <= '0;
      r_cw    <= '0;
      r_id    <= 1'b0;
      r_err   <= '0;
    end else begin
      if (w_hs) begin
        r_msg <= w_gnt ? req1_data : req0_data;
        r_id  <= w_gnt;
      end
      if (r_state == S_START)
        r_timer <= '0;
      else if (r_state == S_WAIT && !core_done && !w_timeout)
        r_timer <= r_timer + 8'd1;
      if (r_state == S_WAIT && core_done)
        r_cw <= core_cw;
      // An aborted requester counts as served so the other side gets the next tie.
      if (w_timeout) begin
        r_last <= r_id;
        if (r_err != 8'hFF) r_err <= r_err + 8'd1;
      end
      if (r_state == S_RESP && rsp_ready)
        r_last <= r_id;
    end
  end

  assign core_msg = r_msg;
  assign rsp_cw   = r_cw;
  assign rsp_id   = r_id;
  assign err_cnt  = r_err;

endmodule

// File: tb/tb_bch_enc_arbiter.sv
// Bench for bch_enc_arbiter: behavioural core model plus transaction-level
// arbitration/scoreboard model.
module tb_bch_enc_arbiter;
  localparam int T = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [6:0]  req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        core_start;
  logic [6:0]  core_msg;
  logic        core_done = 1'b0;
  logic [14:0] core_cw = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [14:0] rsp_cw;
  logic        rsp_id;
  logic        timeout_err;
  logic [7:0]  err_cnt;

  int passes = 0;
  int total  = 0;

  bch_enc_arbiter #(.MSG_W(7), .CW_W(15), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .core_start(core_start), .core_msg(core_msg),
    .core_done(core_done), .core_cw(core_cw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_cw(rsp_cw), .rsp_id(rsp_id),
    .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] bch(input logic [6:0] m);
    logic [14:0] r;
    r = {m, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (r[i]) r = r ^ (15'h1D1 << (i - 8));
    return {m, r[7:0]};
  endfunction

  // Core model: done pulses core_delay cycles after it sees core_start.
  int          core_delay = 1;
  bit          core_en = 1'b1;
  bit          core_fixed = 1'b0;
  logic [14:0] fixed_cw = '0;
  int          cnt = 0;
  logic [6:0]  cmsg = '0;
  bit          late_done = 1'b0;

  always @(negedge clk) begin
    core_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        core_done = 1'b1;
        late_done = 1'b1;
        core_cw   = core_fixed ? fixed_cw : bch(cmsg);
      end
    end
    if (core_start && core_en) begin
      cnt  = core_delay;
      cmsg = core_msg;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    core_en = 1'b1; core_fixed = 1'b0; core_delay = 1;
    repeat (3) @(negedge clk);
    cnt = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if (core_start !== 1'b0)  $display("FAIL reset_core_start got %b want 0", core_start); else passes++;
    total++; if (rsp_valid !== 1'b0)   $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passes++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_timeout_err got %b want 0", timeout_err); else passes++;
    total++; if (err_cnt !== 8'd0)     $display("FAIL reset_err_cnt got %0d want 0", err_cnt); else passes++;
    total++; if (core_msg !== 7'd0)    $display("FAIL reset_core_msg got %h want 0", core_msg); else passes++;
    total++; if (rsp_cw !== 15'd0)     $display("FAIL reset_rsp_cw got %h want 0", rsp_cw); else passes++;
    total++; if (rsp_id !== 1'b0)      $display("FAIL reset_rsp_id got %b want 0", rsp_id); else passes++;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL reset_first_tie got %b want 01", {req1_ready, req0_ready}); else passes++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_single();
    int lat, starts;
    logic [14:0] cw;
    logic id;
    apply_reset();
    core_fixed = 1'b1; fixed_cw = 15'h2AB5; core_delay = 1; rsp_ready = 1'b1;
    lat = -1; starts = 0; cw = '0; id = 1'b1;
    @(negedge clk);
    req0_valid = 1'b1; req0_data = 7'h55;
    #1;
    total++; if (req0_ready !== 1'b1) $display("FAIL single_ready got %b want 1", req0_ready); else passes++;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      if (core_start) starts++;
      if (k == 1) begin
        total++; if (core_msg !== 7'h55) $display("FAIL single_core_msg got %h want 55", core_msg); else passes++;
      end
      if (rsp_valid && lat < 0) begin lat = k; cw = rsp_cw; id = rsp_id; end
    end
    total++; if (starts != 1)      $display("FAIL single_start_pulses got %0d want 1", starts); else passes++;
    total++; if (lat != 3)         $display("FAIL single_latency got %0d want 3", lat); else passes++;
    total++; if (cw !== 15'h2AB5)  $display("FAIL single_rsp_cw got %h want 2ab5", cw); else passes++;
    total++; if (id !== 1'b0)      $display("FAIL single_rsp_id got %b want 0", id); else passes++;
  endtask

  task automatic test_fairness();
    int order[$];
    int both;
    apply_reset();
    core_delay = 1; rsp_ready = 1'b1; both = 0;
    for (int c = 0; c < 80 && order.size() < 4; c++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_data = 7'($urandom); req1_data = 7'($urandom);
      #1;
      if (req0_ready && req1_ready) both++;
      else if (req0_ready) order.push_back(0);
      else if (req1_ready) order.push_back(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    total++; if (both != 0) $display("FAIL fair_both_ready got %0d cycles want 0", both); else passes++;
    total++; if (order.size() != 4) $display("FAIL fair_grant_count got %0d want 4", order.size()); else passes++;
    for (int i = 0; i < order.size() && i < 4; i++) begin
      total++; if (order[i] != (i % 2)) $display("FAIL fair_grant_%0d got %0d want %0d", i, order[i], i % 2); else passes++;
    end
  endtask

  task automatic test_timeout();
    int pulses, at, rsps;
    apply_reset();
    core_en = 1'b0; pulses = 0; at = -1; rsps = 0;
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 7'h2C;
    #1;
    total++; if (req1_ready !== 1'b1) $display("FAIL to_ready got %b want 1", req1_ready); else passes++;
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    total++; if (core_start !== 1'b1) $display("FAIL to_start got %b want 1", core_start); else passes++;
    for (int i = 1; i <= T + 6; i++) begin
      @(negedge clk);
      #1;
      if (timeout_err) begin pulses++; at = i; end
      if (rsp_valid) rsps++;
    end
    total++; if (pulses != 1) $display("FAIL to_pulses got %0d want 1", pulses); else passes++;
    total++; if (at != T)     $display("FAIL to_cycle got %0d want %0d", at, T); else passes++;
    total++; if (err_cnt !== 8'd1) $display("FAIL to_err_cnt got %0d want 1", err_cnt); else passes++;
    total++; if (rsps != 0)   $display("FAIL to_rsp_valid got %0d want 0", rsps); else passes++;
    // Aborted requester 1 counts as last served, so requester 0 wins the tie.
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL to_idle_tie got %b want 01", {req1_ready, req0_ready}); else passes++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    core_en = 1'b1;
  endtask

  task automatic test_back_pressure();
    logic [6:0]  d;
    logic [14:0] cw;
    logic        id;
    bit          seen;
    int          unstable;
    apply_reset();
    core_delay = 2; rsp_ready = 1'b0; d = 7'($urandom); seen = 1'b0; unstable = 0;
    cw = '0; id = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_data = d;
    for (int c = 0; c < 12 && !seen; c++) begin
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      if (rsp_valid) begin seen = 1'b1; cw = rsp_cw; id = rsp_id; end
    end
    total++; if (!seen) $display("FAIL bp_rsp_seen got 0 want 1"); else passes++;
    total++; if (cw !== bch(d)) $display("FAIL bp_rsp_cw got %h want %h", cw, bch(d)); else passes++;
    total++; if (id !== 1'b1)   $display("FAIL bp_rsp_id got %b want 1", id); else passes++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      if (!rsp_valid || rsp_cw !== cw || rsp_id !== id || req0_ready || req1_ready) unstable++;
    end
    total++; if (unstable != 0) $display("FAIL bp_hold got %0d bad cycles want 0", unstable); else passes++;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    total++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got %b want 0", rsp_valid); else passes++;
    total++; if ({req1_ready, req0_ready} !== 2'b01)
      $display("FAIL bp_idle_tie got %b want 01", {req1_ready, req0_ready}); else passes++;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    int bad;
    apply_reset();
    core_delay = 5; rsp_ready = 1'b1; bad = 0; late_done = 1'b0;
    @(negedge clk);
    req1_valid = 1'b1; req1_data = 7'h7F;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || core_start || timeout_err) bad++;
    end
    total++; if (!late_done)        $display("FAIL rmw_core_done got 0 want 1"); else passes++;
    total++; if (bad != 0)          $display("FAIL rmw_activity got %0d want 0", bad); else passes++;
    total++; if (core_msg !== 7'd0) $display("FAIL rmw_core_msg got %h want 0", core_msg); else passes++;
    total++; if (rsp_cw !== 15'd0)  $display("FAIL rmw_rsp_cw got %h want 0", rsp_cw); else passes++;
    total++; if (rsp_id !== 1'b0)   $display("FAIL rmw_rsp_id got %b want 0", rsp_id); else passes++;
    total++; if (err_cnt !== 8'd0)  $display("FAIL rmw_err_cnt got %0d want 0", err_cnt); else passes++;
  endtask

  task automatic test_collision();
    int terr, rsps;
    logic [14:0] cw;
    for (int late = 0; late < 2; late++) begin
      apply_reset();
      core_delay = T + late; rsp_ready = 1'b1; terr = 0; rsps = 0; cw = '0;
      @(negedge clk);
      req0_valid = 1'b1; req0_data = 7'h31;
      for (int c = 0; c < T + 8; c++) begin
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        if (timeout_err) terr++;
        if (rsp_valid) begin rsps++; cw = rsp_cw; end
      end
      if (late == 0) begin
        total++; if (terr != 0)   $display("FAIL coll_timeout_err got %0d want 0", terr); else passes++;
        total++; if (rsps != 1)   $display("FAIL coll_rsp got %0d want 1", rsps); else passes++;
        total++; if (cw !== bch(7'h31)) $display("FAIL coll_rsp_cw got %h want %h", cw, bch(7'h31)); else passes++;
        total++; if (err_cnt !== 8'd0)  $display("FAIL coll_err_cnt got %0d want 0", err_cnt); else passes++;
      end else begin
        total++; if (terr != 1)   $display("FAIL late_timeout_err got %0d want 1", terr); else passes++;
        total++; if (rsps != 0)   $display("FAIL late_rsp got %0d want 0", rsps); else passes++;
        total++; if (err_cnt !== 8'd1)  $display("FAIL late_err_cnt got %0d want 1", err_cnt); else passes++;
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  q0[$], q1[$];
    logic [14:0] exp_cw;
    logic        exp_id, last, busy, v0, v1;
    logic [1:0]  exp_rdy;
    int          served, n;
    apply_reset();
    n = 12;
    for (int i = 0; i < n / 2; i++) begin q0.push_back(7'($urandom)); q1.push_back(7'($urandom)); end
    last = 1'b1; busy = 1'b0; served = 0; exp_cw = '0; exp_id = 1'b0;
    for (int c = 0; c < 3000 && served < n; c++) begin
      @(negedge clk);
      core_delay = ($urandom_range(0, 9) == 0) ? T : $urandom_range(1, 6);
      v0 = (q0.size() > 0) && ($urandom_range(0, 2) != 0);
      v1 = (q1.size() > 0) && ($urandom_range(0, 2) != 0);
      req0_valid = v0; req1_valid = v1;
      if (q0.size() > 0) req0_data = q0[0];
      if (q1.size() > 0) req1_data = q1[0];
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_rdy = 2'b00;
      if (!busy) begin
        if (v0 && v1) exp_rdy = last ? 2'b01 : 2'b10;
        else          exp_rdy = {v1, v0};
      end
      total++; if ({req1_ready, req0_ready} !== exp_rdy)
        $display("FAIL rnd_ready cyc %0d got %b want %b", c, {req1_ready, req0_ready}, exp_rdy); else passes++;
      if (!busy && exp_rdy != 2'b00) begin
        busy   = 1'b1;
        exp_id = exp_rdy[1];
        exp_cw = exp_id ? bch(q1.pop_front()) : bch(q0.pop_front());
      end else if (rsp_valid && rsp_ready) begin
        total++; if (!busy || rsp_id !== exp_id || rsp_cw !== exp_cw)
          $display("FAIL rnd_rsp cyc %0d got id %b cw %h want id %b cw %h busy %b", c, rsp_id, rsp_cw, exp_id, exp_cw, busy);
        else passes++;
        last = exp_id; busy = 1'b0; served++;
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    total++; if (served != n) $display("FAIL rnd_served got %0d want %0d", served, n); else passes++;
    total++; if (err_cnt !== 8'd0) $display("FAIL rnd_err_cnt got %0d want 0", err_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_back_pressure();
    test_reset_mid_wait();
    test_collision();
    test_random();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule
